core85_bus_trace: RTL and testbench
===================================

# core85_bus_trace

Synthesizable bus-cycle tracer for the core85 8085-compatible core. It watches the core's multiplexed bus and status pins on the system clock and classifies each machine cycle. Each cycle becomes a timestamped record {timestamp, cycle type, address, data}, buffered in a parametrised FIFO for a host or bench readout port. It replaces the simulation-only cycle decoding and halt detection with hardware that works on FPGA as well as in simulation.

## Interface
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- TS_W, 16: timestamp counter width; minimum 8.
- REC_W, TS_W+27: record width, derived; do not override. Layout is {ts[TS_W], type[3], addr[16], data[8]}.
- clk  in  1  system clock; the same clock that drives core85.
- rst_  in  1  reset, asynchronous and active-low.
- en  in  1  capture enable. While low, no new cycle is started; a cycle in progress completes.
- clr  in  1  synchronous one-cycle pulse: flush FIFO, clear ovf and halt_seen, zero the timestamp counter.
- addrdata  in  8  multiplexed AD7..AD0 from the core.
- addrhigh  in  8  A15..A8 from the core.
- ale, iom_, s1, s0, rd_, wr_, inta_  in  1 each  core status and strobe pins.
- rec_valid  out  1  FIFO not empty.
- rec_ready  in  1  consumer accepts the head record when rec_valid is high.
- rec_data  out  REC_W  head record; valid only while rec_valid is high.
- level  out  $clog2(DEPTH)+1  current occupancy.
- ovf  out  1  sticky; set when a record is dropped.
- halt_seen  out  1  sticky; set when a HALT record is committed.

## Operation
- Type codes:
  - 0 opcode fetch: iom_=0, s1=1, s0=1
  - 1 memory read: 0,1,0
  - 2 memory write: 0,0,1
  - 3 I/O read: 1,1,0
  - 4 I/O write: 1,0,1
  - 5 interrupt acknowledge: 1,1,1
  - 6 halt: s1=s0=0, iom_ ignored
  - 7 aborted cycle
- Timestamp counter runs free from reset, increments every clk, and wraps at 2^TS_W.
- State machine: IDLE, ADDR, DATA, COMMIT.
  - IDLE: if en=1 and ale=1, go to ADDR.
  - ADDR: while ale=1, latch {addrhigh,addrdata}, status and timestamp every clk (last value wins). When ale=0: halt type goes to COMMIT with data=00; otherwise go to DATA.
  - DATA: latch addrdata every clk while the cycle strobe is low. The strobe is rd_ for types 0,1,3; wr_ for types 2,4; inta_ for type 5. On the strobe's rising edge (sampled previous=0, current=1), go to COMMIT holding the last latched data. If ale=1 arrives before any strobe edge, commit a type 7 record (latched address, data=00) and re-enter ADDR on the same clk.
  - COMMIT: push the record and return to IDLE. If ale=1 in this cycle, go directly to ADDR.
- FIFO:
  - Push when not full.
  - A push onto a full FIFO is dropped and sets ovf. The stored contents are unchanged.
  - A push and a pop (rec_valid & rec_ready) in the same clk are both performed, even when full. Level stays unchanged.
  - Read and write pointers wrap modulo DEPTH.
- clr has priority over push and pop, and also returns the FSM to IDLE.

## Timing
- Reset values: rec_valid=0, level=0, ovf=0, halt_seen=0, rec_data=0, FSM in IDLE, timestamp=0.
- Inputs are sampled on the clk rising edge. No input synchronisers; the core shares clk.
- Latency: a record is visible on rec_valid 1 clk after the COMMIT state (registered FIFO write).
- Record timestamp = counter value on the last clk with ale=1.
- rec_data is first-word-fall-through and stable while rec_valid=1 and rec_ready=0.
- halt_seen rises on the same edge that writes the halt record into the FIFO. It also sets when that record is dropped for overflow.
- Asserting rst_ in mid-cycle discards any partial record immediately (asynchronous).

## Configuration
- TRACE_FILTER_EN:
  - Defined: adds input type_mask[7:0]. A record whose type bit is 0 is not pushed, does not set ovf, and still updates halt_seen for type 6.
  - Undefined: no port is added and all types are pushed.

## Test plan
- Reset, then an opcode fetch at 0x0000 returning 0x3E (MVI A) -> one record: type 0, addr 0000, data 3E, with ts equal to the ale-high clk count; level=1.
- Memory write of 0x55 to 0x2000, then I/O read of 0xA5 from port 0x40 (addrhigh=addrdata=40) -> records (2,2000,55) then (3,4040,A5) in order.
- ale pulses twice with no strobe between them -> a type 7 record for the first address, then a normal record for the second.
- DEPTH=4 with rec_ready=0 and 6 cycles -> level=4, ovf=1, the first 4 records kept. Then a pop and a push in the same clk -> level stays 4.
- HLT fetch (76) followed by halt status s1=s0=0 -> records (0,pc,76) and (6,pc+1,00); halt_seen=1. A clr pulse -> level=0, ovf=0, halt_seen=0.
- With TRACE_FILTER_EN and type_mask=0x01 -> only opcode fetches are recorded, and a halt still sets halt_seen.

Source files
------------

// File: rtl/core85_bus_trace.sv
// -----------------------------------------------------------------------------
// core85_bus_trace
//
// Bus-cycle tracer for the core85 8085-compatible core. It watches the
// multiplexed AD bus, A15..A8 and the status/strobe pins on the core clock and
// classifies each machine cycle. Each finished cycle becomes one record:
//    {timestamp[TS_W], type[3], addr[16], data[8]}
// These records go into a first-word-fall-through FIFO for host readout.
//
// Type codes:
//    0 fetch, 1 mem rd, 2 mem wr, 3 io rd, 4 io wr, 5 inta, 6 halt, 7 aborted
//
// Parameters:
//    DEPTH  FIFO entries (power of two, >= 2)
//    TS_W   timestamp width (>= 8)
//    REC_W  record width, derived as TS_W+27 (leave at default)
//
// Ports:
//    clk, rst_            core clock, asynchronous active-low reset
//    en                   capture enable; a cycle in progress still completes
//    clr                  one-cycle flush: FIFO, ovf, halt_seen, timestamp, FSM
//    addrdata, addrhigh   AD7..AD0 and A15..A8 from the core
//    ale, iom_, s1, s0    core status pins
//    rd_, wr_, inta_      core strobes (active low)
//    type_mask            only with TRACE_FILTER_EN: per-type record enable
//    rec_valid/ready      FIFO head handshake. A record transfers on a clk
//                         edge where both are high. rec_data is stable while
//                         rec_valid=1 and rec_ready=0.
//    rec_data             head record; zero while empty
//    level                FIFO occupancy
//    ovf                  sticky: a record was dropped on a full FIFO
//    halt_seen            sticky: a halt record was committed
//    dbg_state            current FSM state (IDLE=0, ADDR=1, DATA=2, COMMIT=3)
//
// Optional feature macro: TRACE_FILTER_EN (adds type_mask).
// -----------------------------------------------------------------------------
module core85_bus_trace #(
   parameter int DEPTH = 16,
   parameter int TS_W  = 16,
   parameter int REC_W = TS_W + 27
) (
   input  logic                     clk,
   input  logic                     rst_,
   input  logic                     en,
   input  logic                     clr,
   input  logic [7:0]               addrdata,
   input  logic [7:0]               addrhigh,
   input  logic                     ale,
   input  logic                     iom_,
   input  logic                     s1,
   input  logic                     s0,
   input  logic                     rd_,
   input  logic                     wr_,
   input  logic                     inta_,
`ifdef TRACE_FILTER_EN
   input  logic [7:0]               type_mask,
`endif
   output logic                     rec_valid,
   input  logic                     rec_ready,
   output logic [REC_W-1:0]         rec_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ovf,
   output logic                     halt_seen,
   output logic [1:0]               dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ADDR   = 2'd1,
      S_DATA   = 2'd2,
      S_COMMIT = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [15:0]       addr_q, addr_d;
   logic [2:0]        type_q, type_d;
   logic [TS_W-1:0]   tsl_q, tsl_d;     // timestamp latched on the ale clk
   logic [7:0]        data_q, data_d;
   logic              strobe_prev_q, strobe_prev_d;
   logic [TS_W-1:0]   ts_q, ts_d;

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              halt_q, halt_d;
   logic [REC_W-1:0]  mem_q [DEPTH];

   logic [2:0]        stat_type;
   logic              cur_strobe;
   logic              latch_new;
   logic              push_req;
   logic [2:0]        push_type;
   logic [7:0]        push_data;
   logic [REC_W-1:0]  push_rec;
   logic              type_keep;
   logic              pop;
   logic              full;
   logic              wr_en;
   logic              drop;

   // Status pins to cycle type. s1=s0=0 is halt regardless of iom_.
   always_comb begin
      stat_type = 3'd7;
      if (!s1 && !s0) begin
         stat_type = 3'd6;
      end else begin
         case ({iom_, s1, s0})
            3'b011:  stat_type = 3'd0;
            3'b010:  stat_type = 3'd1;
            3'b001:  stat_type = 3'd2;
            3'b110:  stat_type = 3'd3;
            3'b101:  stat_type = 3'd4;
            3'b111:  stat_type = 3'd5;
            default: stat_type = 3'd7;
         endcase
      end
   end

   // The strobe that closes the data phase depends on the latched cycle type.
   always_comb begin
      cur_strobe = 1'b1;
      case (type_q)
         3'd0, 3'd1, 3'd3: cur_strobe = rd_;
         3'd2, 3'd4:       cur_strobe = wr_;
         3'd5:             cur_strobe = inta_;
         default:          cur_strobe = 1'b1;
      endcase
   end

   // Cycle FSM
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      type_d        = type_q;
      tsl_d         = tsl_q;
      data_d        = data_q;
      strobe_prev_d = cur_strobe;
      latch_new     = 1'b0;
      push_req      = 1'b0;
      push_type     = type_q;
      push_data     = data_q;

      case (state_q)
         S_IDLE: begin
            if (en && ale) begin
               state_d   = S_ADDR;
               latch_new = 1'b1;
            end
         end
         S_ADDR: begin
            if (ale) begin
               latch_new = 1'b1;
            end else if (type_q == 3'd6) begin
               state_d = S_COMMIT;
               data_d  = 8'h00;
            end else begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (!strobe_prev_q && cur_strobe) begin
               state_d = S_COMMIT;
            end else if (ale) begin
               // A new ale before the strobe closed: record the old cycle
               // as aborted and start capturing the new one on this clk.
               push_req  = 1'b1;
               push_type = 3'd7;
               push_data = 8'h00;
               if (en) begin
                  state_d   = S_ADDR;
                  latch_new = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (!cur_strobe) begin
               data_d = addrdata;
            end
         end
         S_COMMIT: begin
            push_req = 1'b1;
            if (en && ale) begin
               state_d   = S_ADDR;
               latch_new = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (latch_new) begin
         addr_d = {addrhigh, addrdata};
         type_d = stat_type;
         tsl_d  = ts_q;
         data_d = 8'h00;
      end

      if (clr) begin
         state_d = S_IDLE;
      end
   end

   assign push_rec = {tsl_q, push_type, addr_q, push_data};

`ifdef TRACE_FILTER_EN
   assign type_keep = type_mask[push_type];
`else
   assign type_keep = 1'b1;
`endif

   // FIFO control. With a pop in the same clk a full FIFO still accepts the
   // push: the slot being written is the head that leaves on this edge.
   assign pop   = rec_valid && rec_ready;
   assign full  = (count_q == CW'(DEPTH));
   assign wr_en = push_req && type_keep && (!full || pop) && !clr;
   assign drop  = push_req && type_keep && full && !pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      halt_d   = halt_q;
      ts_d     = ts_q + TS_W'(1);

      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         halt_d   = 1'b0;
         ts_d     = '0;
      end else begin
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         if (wr_en && !pop) begin
            count_d = count_q + CW'(1);
         end else if (!wr_en && pop) begin
            count_d = count_q - CW'(1);
         end
         if (drop) begin
            ovf_d = 1'b1;
         end
         // Halt is flagged even when the record is dropped or filtered out.
         if (push_req && (push_type == 3'd6)) begin
            halt_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q       <= S_IDLE;
         addr_q        <= '0;
         type_q        <= '0;
         tsl_q         <= '0;
         data_q        <= '0;
         strobe_prev_q <= 1'b1;
         ts_q          <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         ovf_q         <= 1'b0;
         halt_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         type_q        <= type_d;
         tsl_q         <= tsl_d;
         data_q        <= data_d;
         strobe_prev_q <= strobe_prev_d;
         ts_q          <= ts_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         ovf_q         <= ovf_d;
         halt_q        <= halt_d;
      end
   end

   // Storage needs no reset: rec_data is gated by rec_valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= push_rec;
      end
   end

   assign rec_valid = (count_q != '0);
   assign rec_data  = rec_valid ? mem_q[rd_ptr_q] : '0;
   assign level     = count_q;
   assign ovf       = ovf_q;
   assign halt_seen = halt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_core85_bus_trace.sv
// -----------------------------------------------------------------------------
// tb_core85_bus_trace
//
// Directed bench for core85_bus_trace (DEPTH=4). Bus cycles are driven
// 8085-style: ale for one clk, strobe low for two clks, strobe high, then one
// commit clk. Expected records are built from the cycle arguments and an
// independent timestamp model, and queued in exp_q.
// -----------------------------------------------------------------------------
module tb_core85_bus_trace;

   localparam int DEPTH = 4;
   localparam int TS_W  = 16;
   localparam int REC_W = TS_W + 27;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic              clk;
   logic              rst_;
   logic              en;
   logic              clr;
   logic [7:0]        addrdata;
   logic [7:0]        addrhigh;
   logic              ale, iom_, s1, s0, rd_, wr_, inta_;
   logic              rec_valid;
   logic              rec_ready;
   logic [REC_W-1:0]  rec_data;
   logic [LW-1:0]     level;
   logic              ovf;
   logic              halt_seen;
   logic [1:0]        dbg_state;
`ifdef TRACE_FILTER_EN
   logic [7:0]        type_mask;
`endif

   int                n_checks = 0;
   int                n_fail   = 0;
   logic [REC_W-1:0]  exp_q[$];
   logic [TS_W-1:0]   tb_ts;

   core85_bus_trace #(
      .DEPTH(DEPTH),
      .TS_W (TS_W)
   ) dut (
      .clk       (clk),
      .rst_      (rst_),
      .en        (en),
      .clr       (clr),
      .addrdata  (addrdata),
      .addrhigh  (addrhigh),
      .ale       (ale),
      .iom_      (iom_),
      .s1        (s1),
      .s0        (s0),
      .rd_       (rd_),
      .wr_       (wr_),
      .inta_     (inta_),
`ifdef TRACE_FILTER_EN
      .type_mask (type_mask),
`endif
      .rec_valid (rec_valid),
      .rec_ready (rec_ready),
      .rec_data  (rec_data),
      .level     (level),
      .ovf       (ovf),
      .halt_seen (halt_seen),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset / timestamp model ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_) begin
      if (!rst_)     tb_ts <= '0;
      else if (clr)  tb_ts <= '0;
      else           tb_ts <= tb_ts + TS_W'(1);
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [2:0] stat_bits(input logic [2:0] typ);
      case (typ)
         3'd0:    return 3'b011;
         3'd1:    return 3'b010;
         3'd2:    return 3'b001;
         3'd3:    return 3'b110;
         3'd4:    return 3'b101;
         3'd5:    return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

   task automatic set_strobe(input logic [2:0] typ, input logic v);
      case (typ)
         3'd0, 3'd1, 3'd3: rd_   = v;
         3'd2, 3'd4:       wr_   = v;
         3'd5:             inta_ = v;
         default: ;
      endcase
   endtask

   // One bus cycle; queues the expected record when keep=1. pop_at_commit
   // raises rec_ready on the commit clk only.
   task automatic bus_cycle(input logic [2:0] typ, input logic [15:0] addr,
                            input logic [7:0] data, input bit keep, input bit pop_at_commit);
      logic [REC_W-1:0] rec;
      rec = {tb_ts, typ, addr, ((typ == 3'd6) ? 8'h00 : data)};
      {iom_, s1, s0} = stat_bits(typ);
      ale      = 1'b1;
      addrhigh = addr[15:8];
      addrdata = addr[7:0];
      step();
      ale = 1'b0;
      if (typ == 3'd6) begin
         addrdata = 8'h00;
         step();
      end else begin
         addrdata = data;
         set_strobe(typ, 1'b0);
         step();
         step();
         set_strobe(typ, 1'b1);
         step();
      end
      rec_ready = pop_at_commit;
      step();
      rec_ready = 1'b0;
      if (keep) exp_q.push_back(rec);
   endtask

   // ---------------- scoreboard drain ----------------
   task automatic drain_n(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         if (exp_q.size() == 0) begin
            check_eq({tag, " queue"}, 64'(i), 64'(n));
            return;
         end
         check_eq({tag, " valid"}, 64'(rec_valid), 64'd1);
         check_eq({tag, " rec"}, 64'(rec_data), 64'(exp_q.pop_front()));
         rec_ready = 1'b1;
         step();
         rec_ready = 1'b0;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_      = 1'b0;
      en        = 1'b1;
      clr       = 1'b0;
      rec_ready = 1'b0;
      ale       = 1'b0;
      addrdata  = 8'h00;
      addrhigh  = 8'h00;
      {iom_, s1, s0} = 3'b011;
      rd_       = 1'b1;
      wr_       = 1'b1;
      inta_     = 1'b1;
`ifdef TRACE_FILTER_EN
      type_mask = 8'hFF;
`endif

      repeat (3) @(negedge clk);
      check_eq("rst rec_valid", 64'(rec_valid), 64'd0);
      check_eq("rst level", 64'(level), 64'd0);
      check_eq("rst ovf", 64'(ovf), 64'd0);
      check_eq("rst halt_seen", 64'(halt_seen), 64'd0);
      check_eq("rst rec_data", 64'(rec_data), 64'd0);
      check_eq("rst state", 64'(dbg_state), 64'd0);
      rst_ = 1'b1;
      repeat (3) step();

      // Opcode fetch MVI A at 0000 (ts = 3 clks after reset release)
      bus_cycle(3'd0, 16'h0000, 8'h3E, 1'b1, 1'b0);
      check_eq("fetch level", 64'(level), 64'd1);
      check_eq("fetch ts", 64'(rec_data[REC_W-1 -: TS_W]), 64'd3);
      drain_n(1, "fetch");
      check_eq("fetch level after pop", 64'(level), 64'd0);

      // Memory write then I/O read
      bus_cycle(3'd2, 16'h2000, 8'h55, 1'b1, 1'b0);
      bus_cycle(3'd3, 16'h4040, 8'hA5, 1'b1, 1'b0);
      check_eq("wr/io level", 64'(level), 64'd2);
      drain_n(2, "wr/io");

      // Aborted cycle: ale, then a second ale with no strobe in between
      {iom_, s1, s0} = stat_bits(3'd1);
      ale      = 1'b1;
      addrhigh = 8'h12;
      addrdata = 8'h34;
      exp_q.push_back({tb_ts, 3'd7, 16'h1234, 8'h00});
      step();
      ale = 1'b0;
      step();
      bus_cycle(3'd1, 16'h5678, 8'h9A, 1'b1, 1'b0);
      check_eq("abort level", 64'(level), 64'd2);
      drain_n(2, "abort");

      // Overflow: six cycles into four entries
      for (int i = 0; i < 6; i++)
         bus_cycle(3'd1, 16'h3000 + 16'(i), 8'h10 + 8'(i), (i < 4), 1'b0);
      check_eq("ovf level", 64'(level), 64'd4);
      check_eq("ovf flag", 64'(ovf), 64'd1);
      drain_n(4, "ovf");
      check_eq("ovf drained level", 64'(level), 64'd0);

      // Full FIFO: pop and push on the same clk
      for (int i = 0; i < 4; i++)
         bus_cycle(3'd2, 16'h4000 + 16'(i), 8'h20 + 8'(i), 1'b1, 1'b0);
      bus_cycle(3'd2, 16'h4004, 8'h24, 1'b1, 1'b1);
      void'(exp_q.pop_front());
      check_eq("push+pop level", 64'(level), 64'd4);
      drain_n(4, "push+pop");

      // HLT fetch followed by halt status
      bus_cycle(3'd0, 16'h0100, 8'h76, 1'b1, 1'b0);
      bus_cycle(3'd6, 16'h0101, 8'h00, 1'b1, 1'b0);
      check_eq("halt_seen", 64'(halt_seen), 64'd1);
      check_eq("halt level", 64'(level), 64'd2);
      drain_n(1, "hlt fetch");
      check_eq("halt rec", 64'(rec_data), 64'(exp_q[0]));

      // clr flushes everything
      clr = 1'b1;
      step();
      clr = 1'b0;
      exp_q.delete();
      check_eq("clr level", 64'(level), 64'd0);
      check_eq("clr ovf", 64'(ovf), 64'd0);
      check_eq("clr halt_seen", 64'(halt_seen), 64'd0);
      check_eq("clr rec_valid", 64'(rec_valid), 64'd0);
      check_eq("clr rec_data", 64'(rec_data), 64'd0);

      // Timestamp restarted by clr: interrupt acknowledge
      bus_cycle(3'd5, 16'h0200, 8'hFF, 1'b1, 1'b0);
      drain_n(1, "inta");

      // Capture disabled
      en = 1'b0;
      bus_cycle(3'd0, 16'h0300, 8'h00, 1'b0, 1'b0);
      check_eq("en=0 level", 64'(level), 64'd0);
      check_eq("en=0 state", 64'(dbg_state), 64'd0);
      en = 1'b1;

`ifdef TRACE_FILTER_EN
      type_mask = 8'h01;
      bus_cycle(3'd1, 16'h0400, 8'h11, 1'b0, 1'b0);
      bus_cycle(3'd0, 16'h0401, 8'h76, 1'b1, 1'b0);
      bus_cycle(3'd6, 16'h0402, 8'h00, 1'b0, 1'b0);
      check_eq("filter level", 64'(level), 64'd1);
      check_eq("filter halt_seen", 64'(halt_seen), 64'd1);
      check_eq("filter ovf", 64'(ovf), 64'd0);
      drain_n(1, "filter");
      type_mask = 8'hFF;
`endif

      check_eq("final level", 64'(level), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
